// File: rtl/match_report_serializer_pkg.sv
// Shared constants, FSM state type and sizing helper for the match report serializer.
package sad_pkg;

  localparam logic [7:0] HDR_MATCH   = 8'hA5;
  localparam logic [7:0] HDR_TRAILER = 8'h5A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAY,
    ST_THDR,
    ST_TCNT
  } state_t;

  function automatic int unsigned bytes_for(input int unsigned bits);
    return (bits + 7) / 8;
  endfunction

endpackage

// File: rtl/match_report_serializer_fifo.sv
// Synchronous show-ahead FIFO; a push while full is accepted only with a same-edge pop.
module match_fifo #(
  parameter int unsigned WIDTH = 19,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_pop_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_cnt;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full     = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty    = (r_cnt == '0);
  assign o_pop_data = r_mem[r_rd];
  assign w_do_pop   = i_pop && !o_empty;
  assign w_do_push  = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr] <= i_push_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/match_report_serializer.sv
// Queues match coordinates and serialises them as framed records plus an
// end-of-frame trailer over a valid/ready byte stream to the UART transmitter.
module match_report_serializer
  import sad_pkg::*;
#(
  parameter int unsigned X_WIDTH    = 10,
  parameter int unsigned Y_WIDTH    = 9,
  parameter int unsigned DEPTH      = 8,
  parameter bit          FIRST_ONLY = 1'b0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               frame_start,
  input  logic               frame_done,
  input  logic               match_valid,
  input  logic [X_WIDTH-1:0] match_x,
  input  logic [Y_WIDTH-1:0] match_y,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic [X_WIDTH-1:0] last_x,
  output logic [Y_WIDTH-1:0] last_y,
  output logic               last_valid,
  output logic [7:0]         match_count,
  output logic               overflow,
  output logic               busy
);

  localparam int unsigned RW = X_WIDTH + Y_WIDTH;
  localparam int unsigned NB = bytes_for(RW);
  localparam int unsigned PW = NB * 8;
  localparam int unsigned IW = (NB > 1) ? $clog2(NB) : 1;

  state_t            r_state;
  state_t            w_next;
  logic [IW-1:0]     r_idx;
  logic              r_trl;
  logic [7:0]        r_snap;
  logic [7:0]        r_count;
  logic              r_ovf;
  logic              r_found;
  logic              r_last_valid;
  logic [X_WIDTH-1:0] r_last_x;
  logic [Y_WIDTH-1:0] r_last_y;

  logic              w_xfer;
  logic              w_pop;
  logic              w_push;
  logic              w_full;
  logic              w_empty;
  logic [RW-1:0]     w_head;
  logic [PW-1:0]     w_rec_pad;
  logic [7:0]        w_pay_byte;
  logic [7:0]        w_count_base;
  logic [7:0]        w_count_next;

  assign w_xfer = tx_valid && tx_ready;
  assign w_pop  = (r_state == ST_PAY) && w_xfer && (r_idx == IW'(NB - 1));
  // frame_start on the same edge re-arms first-match eligibility before the match is judged
  assign w_push = match_valid && (!FIRST_ONLY || !(r_found && !frame_start));

  assign w_count_base = frame_start ? 8'd0 : r_count;
  assign w_count_next = (match_valid && (w_count_base != 8'hFF)) ? w_count_base + 8'd1
                                                                 : w_count_base;

  match_fifo #(
    .WIDTH (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_data ({match_x, match_y}),
    .i_pop       (w_pop),
    .o_pop_data  (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (!w_empty)   w_next = ST_HDR;
        else if (r_trl) w_next = ST_THDR;
      end
      ST_HDR:  if (w_xfer) w_next = ST_PAY;
      ST_PAY:  if (w_pop)  w_next = ST_IDLE;
      ST_THDR: if (w_xfer) w_next = ST_TCNT;
      ST_TCNT: if (w_xfer) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_rec_pad = PW'(w_head);

  always_comb begin
    w_pay_byte = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      if (r_idx == IW'(b)) w_pay_byte = w_rec_pad[(NB-1-b)*8 +: 8];
    end
  end

  always_comb begin
    tx_valid = 1'b0;
    tx_data  = '0;
    unique case (r_state)
      ST_HDR:  begin tx_valid = 1'b1; tx_data = HDR_MATCH;   end
      ST_PAY:  begin tx_valid = 1'b1; tx_data = w_pay_byte;  end
      ST_THDR: begin tx_valid = 1'b1; tx_data = HDR_TRAILER; end
      ST_TCNT: begin tx_valid = 1'b1; tx_data = r_snap;      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_idx <= '0;
    end else if ((r_state == ST_PAY) && w_xfer) begin
      r_idx <= w_pop ? '0 : r_idx + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_trl  <= 1'b0;
      r_snap <= '0;
    end else if (frame_done) begin
      r_trl  <= 1'b1;
      r_snap <= w_count_next;
    end else if ((r_state == ST_TCNT) && w_xfer) begin
      r_trl  <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_count      <= '0;
      r_ovf        <= 1'b0;
      r_found      <= 1'b0;
      r_last_valid <= 1'b0;
      r_last_x     <= '1;
      r_last_y     <= '1;
    end else begin
      r_count <= w_count_next;
      if (frame_start) begin
        r_ovf   <= 1'b0;
        r_found <= 1'b0;
      end
      if (match_valid) begin
        r_found      <= 1'b1;
        r_last_valid <= 1'b1;
        r_last_x     <= match_x;
        r_last_y     <= match_y;
      end
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  assign match_count = r_count;
  assign overflow    = r_ovf;
  assign last_valid  = r_last_valid;
  assign last_x      = r_last_x;
  assign last_y      = r_last_y;
  assign busy        = (r_state != ST_IDLE) || !w_empty || r_trl;

endmodule

// File: tb/tb_match_report_serializer.sv
// Drives two serializer instances (all matches / first-only) and compares every
// output each cycle against a queue-based reference model of the byte stream.
module tb_match_report_serializer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset;
  logic       fs [2];
  logic       fd [2];
  logic       mv [2];
  logic       rdy[2];
  logic [9:0] mx [2];
  logic [8:0] my [2];
  logic [7:0] txd[2];
  logic       txv[2];
  logic [9:0] lx [2];
  logic [8:0] ly [2];
  logic       lv [2];
  logic [7:0] mc [2];
  logic       ov [2];
  logic       bz [2];

  match_report_serializer #(
    .X_WIDTH(10), .Y_WIDTH(9), .DEPTH(8), .FIRST_ONLY(1'b0)
  ) dut0 (
    .clock(clock), .reset(reset), .frame_start(fs[0]), .frame_done(fd[0]),
    .match_valid(mv[0]), .match_x(mx[0]), .match_y(my[0]),
    .tx_data(txd[0]), .tx_valid(txv[0]), .tx_ready(rdy[0]),
    .last_x(lx[0]), .last_y(ly[0]), .last_valid(lv[0]),
    .match_count(mc[0]), .overflow(ov[0]), .busy(bz[0])
  );

  match_report_serializer #(
    .X_WIDTH(10), .Y_WIDTH(9), .DEPTH(8), .FIRST_ONLY(1'b1)
  ) dut1 (
    .clock(clock), .reset(reset), .frame_start(fs[1]), .frame_done(fd[1]),
    .match_valid(mv[1]), .match_x(mx[1]), .match_y(my[1]),
    .tx_data(txd[1]), .tx_valid(txv[1]), .tx_ready(rdy[1]),
    .last_x(lx[1]), .last_y(ly[1]), .last_valid(lv[1]),
    .match_count(mc[1]), .overflow(ov[1]), .busy(bz[1])
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input int inst,
                           input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s[%0d] got=%0h expected=%0h at %0t", tag, inst, got, exp, $time);
    end
  endtask

  // Reference model: queued records, bytes of the item currently offered, frame state.
  logic [18:0] m_qa  [2][8];
  int          m_qn  [2];
  logic [7:0]  m_cur [2][4];
  int          m_curn[2];
  bit          m_rec [2];
  bit          m_trl [2];
  logic [7:0]  m_snap[2];
  logic [7:0]  m_cnt [2];
  bit          m_ovf [2];
  bit          m_found[2];
  bit          m_lv  [2];
  logic [9:0]  m_lx  [2];
  logic [8:0]  m_ly  [2];

  logic [7:0] cap[$];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_qn[i] = 0; m_curn[i] = 0; m_rec[i] = 0; m_trl[i] = 0;
      m_snap[i] = 8'd0; m_cnt[i] = 8'd0; m_ovf[i] = 0; m_found[i] = 0;
      m_lv[i] = 0; m_lx[i] = 10'h3FF; m_ly[i] = 9'h1FF;
    end
  endtask

  task automatic model_step(input int i);
    bit pop;
    logic [23:0] pad;
    pop = 0;
    if (m_curn[i] > 0) begin
      if (rdy[i]) begin
        for (int k = 0; k < 3; k++) m_cur[i][k] = m_cur[i][k+1];
        m_curn[i]--;
        if (m_curn[i] == 0) begin
          if (m_rec[i]) pop = 1;
          else          m_trl[i] = 0;
        end
      end
    end else if (m_qn[i] > 0) begin
      pad = {5'd0, m_qa[i][0]};
      m_cur[i][0] = 8'hA5;
      m_cur[i][1] = pad[23:16];
      m_cur[i][2] = pad[15:8];
      m_cur[i][3] = pad[7:0];
      m_curn[i] = 4;
      m_rec[i] = 1;
    end else if (m_trl[i]) begin
      m_cur[i][0] = 8'h5A;
      m_curn[i] = 2;
      m_rec[i] = 0;
    end
    if (pop) begin
      for (int k = 0; k < 7; k++) m_qa[i][k] = m_qa[i][k+1];
      m_qn[i]--;
    end
    if (fs[i]) begin
      m_cnt[i] = 8'd0; m_found[i] = 0; m_ovf[i] = 0;
    end
    if (mv[i]) begin
      m_lx[i] = mx[i]; m_ly[i] = my[i]; m_lv[i] = 1;
      if (m_cnt[i] != 8'd255) m_cnt[i] = m_cnt[i] + 8'd1;
      if (!(i == 1 && m_found[i])) begin
        if (m_qn[i] == 8) m_ovf[i] = 1;
        else begin
          m_qa[i][m_qn[i]] = {mx[i], my[i]};
          m_qn[i]++;
        end
      end
      m_found[i] = 1;
    end
    if (fd[i]) begin
      m_trl[i] = 1;
      m_snap[i] = m_cnt[i];
    end
  endtask

  task automatic check_outputs(input int i);
    logic [7:0] ed;
    if (m_curn[i] == 0)  ed = 8'h00;
    else if (m_rec[i])   ed = m_cur[i][0];
    else                 ed = (m_curn[i] == 2) ? 8'h5A : m_snap[i];
    check_val("tx_valid", i, txv[i], m_curn[i] > 0);
    check_val("tx_data", i, txd[i], ed);
    check_val("busy", i, bz[i], (m_curn[i] > 0) || (m_qn[i] > 0) || m_trl[i]);
    check_val("match_count", i, mc[i], m_cnt[i]);
    check_val("overflow", i, ov[i], m_ovf[i]);
    check_val("last_x", i, lx[i], m_lx[i]);
    check_val("last_y", i, ly[i], m_ly[i]);
    check_val("last_valid", i, lv[i], m_lv[i]);
  endtask

  task automatic cycle();
    if (txv[0] && rdy[0]) cap.push_back(txd[0]);
    @(posedge clock);
    if (reset) model_reset();
    else begin
      model_step(0);
      model_step(1);
    end
    @(negedge clock);
    check_outputs(0);
    check_outputs(1);
  endtask

  task automatic clear_pulses();
    for (int i = 0; i < 2; i++) begin
      fs[i] = 0; fd[i] = 0; mv[i] = 0;
    end
  endtask

  task automatic set_match(input int i, input logic [9:0] x, input logic [8:0] y);
    mv[i] = 1; mx[i] = x; my[i] = y;
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      fs[i] = 0; fd[i] = 0; mv[i] = 0; rdy[i] = 1; mx[i] = '0; my[i] = '0;
    end
    model_reset();
    @(negedge clock);
    repeat (3) cycle();
    reset = 1'b0;

    // default record: 0x155/0x0AB -> A5 02 AA AB
    cap.delete();
    set_match(0, 10'h155, 9'h0AB);
    cycle();
    clear_pulses();
    repeat (8) cycle();
    check_val("rec_len", 0, cap.size(), 4);
    if (cap.size() == 4) begin
      check_val("rec_b0", 0, cap[0], 8'hA5);
      check_val("rec_b1", 0, cap[1], 8'h02);
      check_val("rec_b2", 0, cap[2], 8'hAA);
      check_val("rec_b3", 0, cap[3], 8'hAB);
    end

    // back-pressure on the header
    set_match(0, 10'h2A1, 9'h01F);
    cycle();
    clear_pulses();
    cycle();
    rdy[0] = 0;
    repeat (10) cycle();
    rdy[0] = 1;
    repeat (8) cycle();

    // overflow: 10 matches into a stalled 8-deep queue
    rdy[0] = 0; rdy[1] = 0;
    fs[0] = 1; fs[1] = 1;
    cycle();
    clear_pulses();
    for (int n = 0; n < 10; n++) begin
      set_match(0, 10'($urandom), 9'($urandom));
      set_match(1, 10'($urandom), 9'($urandom));
      cycle();
    end
    clear_pulses();
    cycle();
    check_val("ovf_count", 0, mc[0], 8'd10);
    check_val("ovf_flag", 0, ov[0], 1'b1);
    rdy[0] = 1; rdy[1] = 1;
    repeat (70) cycle();

    // first-only frame with trailer, then frame_start with a same-edge match
    fs[0] = 1; fs[1] = 1;
    cycle();
    clear_pulses();
    for (int n = 0; n < 3; n++) begin
      set_match(0, 10'(n + 1), 9'(n + 7));
      set_match(1, 10'(n + 1), 9'(n + 7));
      cycle();
    end
    clear_pulses();
    fd[0] = 1; fd[1] = 1;
    cycle();
    clear_pulses();
    repeat (30) cycle();
    fs[1] = 1;
    set_match(1, 10'h0F0, 9'h10F);
    cycle();
    clear_pulses();
    check_val("fs_same_edge_count", 1, mc[1], 8'd1);
    repeat (12) cycle();

    // frame_done with two records queued
    rdy[0] = 0;
    set_match(0, 10'h011, 9'h022);
    cycle();
    set_match(0, 10'h033, 9'h044);
    cycle();
    clear_pulses();
    fd[0] = 1;
    cycle();
    clear_pulses();
    rdy[0] = 1;
    repeat (30) cycle();

    // count saturation
    fs[0] = 1;
    cycle();
    clear_pulses();
    for (int n = 0; n < 260; n++) begin
      set_match(0, 10'($urandom), 9'($urandom));
      rdy[0] = ($urandom % 2) == 0;
      cycle();
    end
    clear_pulses();
    rdy[0] = 1;
    check_val("sat_count", 0, mc[0], 8'd255);
    repeat (80) cycle();

    // reset while the payload is being sent
    set_match(0, 10'h155, 9'h0AB);
    cycle();
    clear_pulses();
    cycle();
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check_val("rst_tx_valid", 0, txv[0], 1'b0);
    check_val("rst_busy", 0, bz[0], 1'b0);
    check_val("rst_last_x", 0, lx[0], 10'h3FF);
    check_val("rst_last_valid", 0, lv[0], 1'b0);

    // randomized traffic; frame_done is withheld while a trailer is on the wire
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        rdy[i] = ($urandom % 10) < 7;
        mv[i]  = ($urandom % 4) == 0;
        mx[i]  = 10'($urandom);
        my[i]  = 9'($urandom);
        fs[i]  = ($urandom % 40) == 0;
        fd[i]  = (($urandom % 30) == 0) && !((m_curn[i] > 0) && !m_rec[i]);
      end
      reset = ($urandom % 600) == 0;
      cycle();
    end
    reset = 1'b0;
    clear_pulses();
    rdy[0] = 1; rdy[1] = 1;
    repeat (100) cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/match_report_serializer.md
# match_report_serializer

Parametrised successor to the SAD top-level output stage. It accepts match coordinates from the control unit/processing element, queues them, and serialises each match into a framed byte stream for the UART transmitter over a valid/ready handshake. Unlike the single last-match register it replaces, it keeps every match (or only the first per frame), counts matches, flags overflow, and emits an end-of-frame trailer. It sits between the control unit's `MATCH` indication and the UART TX block.

## Interface
- `X_WIDTH`, 10, x coordinate width (1..16)
- `Y_WIDTH`, 9, y coordinate width (1..16)
- `DEPTH`, 8, queue entries, power of two, 2..64
- `FIRST_ONLY`, 0, 1 = enqueue only the first match after each `frame_start`
- `clock`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high
- `frame_start`  in  1  pulse; clears per-frame state
- `frame_done`  in  1  pulse; requests trailer
- `match_valid`  in  1  pulse; match present this cycle
- `match_x`  in  X_WIDTH  match column
- `match_y`  in  Y_WIDTH  match row
- `tx_data`  out  8  byte to UART
- `tx_valid`  out  1  `tx_data` valid
- `tx_ready`  in  1  UART accepts byte
- `last_x` / `last_y`  out  X_WIDTH / Y_WIDTH  most recent detected match
- `last_valid`  out  1  at least one match since reset
- `match_count`  out  8  matches detected this frame, saturating at 255
- `overflow`  out  1  sticky: a match was dropped this frame
- `busy`  out  1  FSM not IDLE, queue non-empty, or trailer pending

## Operation
- Record = `{match_x, match_y}`, `RW = X_WIDTH+Y_WIDTH` bits, zero-extended on the MSB side to `NB = ceil(RW/8)` bytes (default 3). Sent as header `8'hA5`, then NB bytes MSB first.
- Trailer = `8'h5A`, then the snapshot count byte.
- On `match_valid`:
  - `last_*` update and `last_valid` is set.
  - `match_count` increments (saturating).
  - The record is pushed unless `FIRST_ONLY` is set and a match was already detected this frame.
- Push while full with no same-edge pop: record dropped, `overflow` set. A push and pop on the same edge while full are both accepted.
- `frame_start` clears `match_count`, `overflow` and the first-found flag. Queue contents and any in-flight transfer are untouched. If `match_valid` arrives on the same edge, the clear applies first, so the count becomes 1 and the match is eligible under `FIRST_ONLY`.
- `frame_done` latches `trl_pending` and snapshots `match_count`, including a match on the same edge.
- FSM states IDLE, HDR, PAY, THDR, TCNT:
  - IDLE→HDR if the queue is non-empty (the queue has priority).
  - Otherwise IDLE→THDR if `trl_pending`.
  - HDR→PAY on transfer; PAY stays until byte NB−1 transfers, then pops and goes to IDLE.
  - THDR→TCNT→IDLE on transfers; `trl_pending` clears on the TCNT transfer.
- A second `frame_done` while a trailer is pending overwrites the snapshot and sends one trailer only.

## Timing
- Reset values: `tx_valid` 0, `tx_data` 0, `last_x` all ones, `last_y` all ones, `last_valid` 0, `match_count` 0, `overflow` 0, `busy` 0. FSM goes to IDLE, queue is emptied and `trl_pending` cleared.
- A transfer occurs on an edge with `tx_valid && tx_ready`.
- `tx_data` is stable while `tx_valid && !tx_ready`, and `tx_valid` never drops without a transfer (except on reset).
- Latency: `match_valid` sampled at edge k into an empty queue with FSM in IDLE gives `tx_valid` high with `8'hA5` after edge k+1.
- With `tx_ready` held high, one byte transfers per cycle and consecutive records are separated by one IDLE cycle.
- `last_*` and `match_count` update on the edge that samples `match_valid`.
- Reset mid-transfer aborts the record; no partial-record recovery.

## Structure
- Package `sad_pkg`:
  - `HDR_MATCH = 8'hA5`, `HDR_TRAILER = 8'h5A`.
  - FSM state enum.
  - Function `bytes_for(bits)`.
- Sub-module `match_fifo`: synchronous FIFO, `WIDTH`, `DEPTH`, push/pop/full/empty, show-ahead read.
- Serializer FSM, byte index counter (width `$clog2(NB)`, min 1) and frame counters live in this module.

## Test plan
- Defaults: match (x=0x155, y=0x0AB), `tx_ready`=1 → bytes A5, 02, AA, AB; `match_count`=1; `last_x`=0x155.
- `tx_ready`=0 for 10 cycles after `tx_valid` rises → `tx_data`=A5 held and `tx_valid` stays high; stream resumes unchanged.
- DEPTH=8, `tx_ready`=0, 10 matches → `overflow`=1, `match_count`=10. Release `tx_ready` → exactly 8 records, in order.
- `FIRST_ONLY`=1, 3 matches then `frame_done` → one record, then trailer 5A, 03. `frame_start` with a same-edge match → `match_count`=1 and the match is sent.
- `frame_done` while 2 records are queued → both records sent before 5A with the snapshot count.
- Reset during the PAY state → next cycle `tx_valid`=0, `busy`=0, `last_x`=0x3FF, `last_valid`=0.
